// File: rtl/dbf_rx_seq_if.sv
// rtl/dbf_rx_seq_if.sv - control/status bundle between the line sequencer and its requester
// Optional: DBF_LINE_CNT_EN adds the line_cnt status field.
interface dbf_rx_seq_if #(
  parameter int ADDR_WD = 8
);
  logic               line_req;
  logic               abort;
  logic               tx_en;
  logic               start;
  logic [ADDR_WD-1:0] dbf_lut_addr;
  logic               dbf_lut_we;
  logic               busy;
  logic               line_done;
`ifdef DBF_LINE_CNT_EN
  logic [15:0]        line_cnt;

  // Requester side: issues line requests/aborts, observes the sequencer.
  modport master (
    output line_req, abort,
    input  tx_en, start, dbf_lut_addr, dbf_lut_we, busy, line_done, line_cnt
  );

  // Sequencer side.
  modport slave (
    input  line_req, abort,
    output tx_en, start, dbf_lut_addr, dbf_lut_we, busy, line_done, line_cnt
  );
`else
  // Requester side: issues line requests/aborts, observes the sequencer.
  modport master (
    output line_req, abort,
    input  tx_en, start, dbf_lut_addr, dbf_lut_we, busy, line_done
  );

  // Sequencer side.
  modport slave (
    input  line_req, abort,
    output tx_en, start, dbf_lut_addr, dbf_lut_we, busy, line_done
  );
`endif
endinterface

// File: rtl/dbf_rx_seq.sv
// rtl/dbf_rx_seq.sv - per-scan-line TX / dead-time / RX zone sequencer for the DBF channel array
// Optional: DBF_LINE_CNT_EN adds a 16-bit completed-line counter (line_cnt).
module dbf_rx_seq #(
  parameter int ADDR_WD     = 8,
  parameter int TX_CYCLES   = 64,
  parameter int DEAD_CYCLES = 16,
  parameter int ZONE_LEN    = 128,
  parameter int NUM_ZONES   = 32,
  parameter int CNT_WD      = 16
) (
  input  logic          clk,
  input  logic          rst_n,   // synchronous, active-high despite the name
  dbf_rx_seq_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TX   = 3'd1,
    S_DEAD = 3'd2,
    S_RX   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Terminal counts: the counter runs 0..LEN-1 inside each phase/zone.
  localparam logic [CNT_WD-1:0]  TX_LAST   = CNT_WD'(TX_CYCLES - 1);
  localparam logic [CNT_WD-1:0]  DEAD_LAST = CNT_WD'(DEAD_CYCLES - 1);
  localparam logic [CNT_WD-1:0]  ZONE_LAST = CNT_WD'(ZONE_LEN - 1);
  localparam logic [CNT_WD-1:0]  CNT_ONE   = CNT_WD'(1);
  // Last zone may be all-ones when NUM_ZONES == 2**ADDR_WD; the zone index
  // is compared against it before incrementing, so it never wraps in-line.
  localparam logic [ADDR_WD-1:0] LAST_ZONE = ADDR_WD'(NUM_ZONES - 1);
  localparam logic [ADDR_WD-1:0] ZONE_ONE  = ADDR_WD'(1);

  state_t             state_q, state_d;
  logic [CNT_WD-1:0]  cnt_q, cnt_d;
  logic [ADDR_WD-1:0] zone_q, zone_d;

  logic               tx_en_q, tx_en_d;
  logic               start_q, start_d;
  logic [ADDR_WD-1:0] addr_q, addr_d;
  logic               we_q, we_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Next-state, counter/zone reload and registered-output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    zone_d  = zone_q;
    we_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // abort in the same cycle as line_req suppresses the line.
        if (bus.line_req && !bus.abort) begin
          state_d = S_TX;
          cnt_d   = '0;
        end
      end

      S_TX: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == TX_LAST) begin
          state_d = S_DEAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_DEAD: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEAD_LAST) begin
          // Entering zone 0: strobe the LUT write on the same edge as the address.
          state_d = S_RX;
          cnt_d   = '0;
          zone_d  = '0;
          we_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_RX: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          zone_d  = '0;
        end else if (cnt_q == ZONE_LAST) begin
          cnt_d = '0;
          if (zone_q == LAST_ZONE) begin
            state_d = S_DONE;
            zone_d  = '0;
          end else begin
            zone_d = zone_q + ZONE_ONE;
            we_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_DONE: begin
        // Single-cycle completion state; line_req here is dropped.
        state_d = S_IDLE;
        cnt_d   = '0;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        zone_d  = '0;
      end
    endcase

    // Outputs are decoded from the next state so they register on the same
    // edge as the state change; abort lands everything at reset values.
    tx_en_d = (state_d == S_TX);
    start_d = (state_d == S_RX);
    addr_d  = (state_d == S_RX) ? zone_d : '0;
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      zone_q  <= '0;
      tx_en_q <= 1'b0;
      start_q <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      zone_q  <= zone_d;
      tx_en_q <= tx_en_d;
      start_q <= start_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.tx_en        = tx_en_q;
  assign bus.start        = start_q;
  assign bus.dbf_lut_addr = addr_q;
  assign bus.dbf_lut_we   = we_q;
  assign bus.busy         = busy_q;
  assign bus.line_done    = done_q;

`ifdef DBF_LINE_CNT_EN
  logic [15:0] line_cnt_q, line_cnt_d;

  // Completed-line count: advances with the line_done pulse, wraps naturally.
  always_comb begin
    line_cnt_d = line_cnt_q;
    if (done_d) begin
      line_cnt_d = line_cnt_q + 16'd1;
    end
  end

  // Line counter register.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      line_cnt_q <= '0;
    end else begin
      line_cnt_q <= line_cnt_d;
    end
  end

  assign bus.line_cnt = line_cnt_q;
`endif

endmodule

// File: tb/tb_dbf_rx_seq.sv
// tb/tb_dbf_rx_seq.sv - scoreboard bench for dbf_rx_seq against a cycle-offset reference model
module tb_dbf_rx_seq;

  localparam int ADDR_WD     = 2;
  localparam int TX_CYCLES   = 5;
  localparam int DEAD_CYCLES = 3;
  localparam int ZONE_LEN    = 4;
  localparam int NUM_ZONES   = 4;   // == 2**ADDR_WD: last zone is all-ones
  localparam int CNT_WD      = 8;

  // Offsets measured in cycles after the edge that accepted line_req.
  localparam int RX_BASE = 1 + TX_CYCLES + DEAD_CYCLES;
  localparam int RX_LEN  = NUM_ZONES * ZONE_LEN;
  localparam int LAT     = RX_BASE + RX_LEN;

  typedef struct packed {
    logic               tx_en;
    logic               start;
    logic [ADDR_WD-1:0] addr;
    logic               we;
    logic               busy;
    logic               done;
    logic [15:0]        cnt;
  } obs_t;

  logic clk;
  logic rst_n;

  dbf_rx_seq_if #(.ADDR_WD(ADDR_WD)) bus ();

  dbf_rx_seq #(
    .ADDR_WD    (ADDR_WD),
    .TX_CYCLES  (TX_CYCLES),
    .DEAD_CYCLES(DEAD_CYCLES),
    .ZONE_LEN   (ZONE_LEN),
    .NUM_ZONES  (NUM_ZONES),
    .CNT_WD     (CNT_WD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  obs_t exp_q[$];

  // Reference model state: whether a line is in flight and its cycle offset.
  bit          m_active = 1'b0;
  int          m_k      = 0;
  logic [15:0] m_cnt    = 16'd0;

  function automatic obs_t model_out(input bit act, input int k, input logic [15:0] c);
    obs_t o;
    bit   rx;
    o      = '0;
    rx     = act && (k >= RX_BASE) && (k < RX_BASE + RX_LEN);
    o.tx_en = act && (k >= 1) && (k <= TX_CYCLES);
    o.start = rx;
    o.addr  = rx ? ADDR_WD'((k - RX_BASE) / ZONE_LEN) : '0;
    o.we    = rx && (((k - RX_BASE) % ZONE_LEN) == 0);
    o.busy  = act;
    o.done  = act && (k == LAT);
`ifdef DBF_LINE_CNT_EN
    o.cnt   = c;
`else
    o.cnt   = 16'd0;
    if (c == 16'hFFFF) o.cnt = 16'd0;
`endif
    return o;
  endfunction

  // Drive one cycle of inputs, advance the model, queue the expected outputs.
  task automatic step(input logic r, input logic a, input logic rs);
    obs_t e;
    @(negedge clk);
    bus.line_req = r;
    bus.abort    = a;
    rst_n        = rs;
    if (rs) begin
      m_active = 1'b0;
      m_k      = 0;
      m_cnt    = 16'd0;
    end else if (m_active) begin
      if (a || m_k == LAT) begin
        m_active = 1'b0;
        m_k      = 0;
      end else begin
        m_k = m_k + 1;
      end
    end else if (r && !a) begin
      m_active = 1'b1;
      m_k      = 1;
    end
    if (m_active && m_k == LAT) m_cnt = m_cnt + 16'd1;
    e = model_out(m_active, m_k, m_cnt);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every cycle the DUT presents its registered outputs; compare
  // them against the oldest queued expectation.
  initial begin
    obs_t g, e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e        = exp_q.pop_front();
        g.tx_en  = bus.tx_en;
        g.start  = bus.start;
        g.addr   = bus.dbf_lut_addr;
        g.we     = bus.dbf_lut_we;
        g.busy   = bus.busy;
        g.done   = bus.line_done;
`ifdef DBF_LINE_CNT_EN
        g.cnt    = bus.line_cnt;
`else
        g.cnt    = 16'd0;
`endif
        checks = checks + 1;
        if (g !== e) begin
          failures = failures + 1;
          $display("FAIL outputs t=%0t got tx=%b st=%b addr=%0d we=%b busy=%b done=%b cnt=%0d need tx=%b st=%b addr=%0d we=%b busy=%b done=%b cnt=%0d",
                   $time, g.tx_en, g.start, g.addr, g.we, g.busy, g.done, g.cnt,
                   e.tx_en, e.start, e.addr, e.we, e.busy, e.done, e.cnt);
        end
      end
    end
  end

  initial begin
    int lat;
    bit seen;
    logic r, a, rs;

    bus.line_req = 1'b0;
    bus.abort    = 1'b0;
    rst_n        = 1'b1;

    // Reset held with line_req asserted, then released: nothing may start.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
    idle(5);

    // Nominal line with a bounded latency measurement to line_done.
    step(1'b1, 1'b0, 1'b0);
    lat  = 1;
    seen = 1'b0;
    for (int j = 0; j < LAT + 20 && !seen; j++) begin
      step(1'b0, 1'b0, 1'b0);
      lat = lat + 1;
      @(posedge clk);
      #2;
      if (bus.line_done) seen = 1'b1;
    end
    checks = checks + 1;
    if (!seen || lat != LAT) begin
      failures = failures + 1;
      $display("FAIL latency got=%0d seen=%0d need=%0d", lat, seen, LAT);
    end
    idle(3);

    // Abort in the middle of zone 2.
    step(1'b1, 1'b0, 1'b0);
    idle(RX_BASE + 2 * ZONE_LEN + 1 - 1);
    step(1'b0, 1'b1, 1'b0);
    idle(4);

    // Requests during TX and during DONE are dropped; a request one cycle
    // after busy falls starts a fresh line.
    step(1'b1, 1'b0, 1'b0);
    for (int j = 1; j <= LAT; j++) step((j == 2) || (j == LAT), 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle(LAT + 2);

    // Back-to-back lines.
    for (int n = 0; n < 3; n++) begin
      step(1'b1, 1'b0, 1'b0);
      idle(LAT);
    end

    // abort alone in IDLE, then abort together with line_req.
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    idle(3);

    // Randomized traffic, including aborts in every phase and sporadic resets.
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 7) == 0);
      a  = ($urandom_range(0, 47) == 0);
      rs = ($urandom_range(0, 599) == 0);
      step(r, a, rs);
    end
    idle(LAT + 4);

    repeat (3) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
